inst_axi_rd_bridge: RTL and testbench

//  Responder side of the fetch stage's AXI user interface (axi_start/axi_addr -> axi_done/axi_rdata/axi_busy).

---
 rtl/inst_axi_rd_bridge.sv | 130 +++++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: turns each one-cycle fetch request into one single-beat
// AXI4 read (AR then R) and hands the word back with a one-cycle done pulse.
// Optional feature macro: INST_AXI_RD_ERR_EN. When it is defined, an error
// response substitutes ERR_DATA for the read word and raises axi_rerr.
//
// Handshake rule used on both AXI channels: a transfer happens on a rising
// clock edge where valid and ready are both high. arvalid stays high with
// araddr stable until that edge, and rready is high only while waiting for
// the one R beat. Data presented outside that window is not consumed.
module inst_axi_rd_bridge #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 ID_W     = 4,
  parameter logic [ID_W-1:0]    ARID_VAL = '0,
  parameter logic [DATA_W-1:0]  ERR_DATA = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              axi_start,
  input  logic [ADDR_W-1:0] axi_addr,
  output logic              axi_done,
  output logic [DATA_W-1:0] axi_rdata,
  output logic              axi_busy,
`ifdef INST_AXI_RD_ERR_EN
  output logic              axi_rerr,
`endif
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; reset aborts any read in flight immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one pass IDLE -> AR -> R -> DONE -> IDLE per accepted start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (axi_start) state_d = S_AR;
      S_AR:    if (arready)   state_d = S_R;
      S_R:     if (rvalid)    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decode straight from the state so that an
  // asynchronous reset drops them without waiting for a clock edge.
  assign arvalid   = (state_q == S_AR);
  assign rready    = (state_q == S_R);
  assign axi_done  = (state_q == S_DONE);
  assign axi_busy  = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // Single-beat, word-sized INCR read with a fixed ID.
  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Address capture on an accepted start (word aligned) and data capture on
  // the R beat; the word is held until the next beat replaces it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr    <= '0;
      axi_rdata <= '0;
    end else begin
      if (state_q == S_IDLE && axi_start) begin
        araddr <= {axi_addr[ADDR_W-1:2], 2'b00};
      end
      if (state_q == S_R && rvalid) begin
`ifdef INST_AXI_RD_ERR_EN
        axi_rdata <= rresp[1] ? ERR_DATA : rdata;
`else
        axi_rdata <= rdata;
`endif
      end
    end
  end

`ifdef INST_AXI_RD_ERR_EN
  // Error flag: set with the returned word on SLVERR/DECERR, cleared when the
  // next request is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      axi_rerr <= 1'b0;
    end else if (state_q == S_IDLE && axi_start) begin
      axi_rerr <= 1'b0;
    end else if (state_q == S_R && rvalid) begin
      axi_rerr <= rresp[1];
    end
  end

  // rid, rlast and the low response bit carry no information for this block.
  logic unused_ok;
  assign unused_ok = ^{rid, rlast, rresp[0], axi_addr[1:0]};
`else
  // Without error handling the response code and error word play no part.
  logic unused_ok;
  assign unused_ok = ^{rid, rlast, rresp, axi_addr[1:0], ERR_DATA};
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// tb_inst_axi_rd_bridge: directed checks of inst_axi_rd_bridge plus a
// per-cycle handshake-level model and a scoreboard of returned words.
module tb_inst_axi_rd_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam logic [ID_W-1:0] ARID = 4'h5;

  logic              clk;
  logic              resetn;
  logic              axi_start;
  logic [ADDR_W-1:0] axi_addr;
  logic              axi_done;
  logic [DATA_W-1:0] axi_rdata;
  logic              axi_busy;
  logic              axi_rerr;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [1:0]        dbg_state;

  inst_axi_rd_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .ARID_VAL(ARID)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .axi_start(axi_start),
    .axi_addr (axi_addr),
    .axi_done (axi_done),
    .axi_rdata(axi_rdata),
    .axi_busy (axi_busy),
`ifdef INST_AXI_RD_ERR_EN
    .axi_rerr (axi_rerr),
`endif
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arvalid  (arvalid),
    .arready  (arready),
    .rid      (rid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready),
    .dbg_state(dbg_state)
  );

`ifndef INST_AXI_RD_ERR_EN
  assign axi_rerr = 1'b0;
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / checker ----------------
  int n_vec  = 0;
  int n_fail = 0;
  int ar_hs  = 0;

  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_word(input logic [DATA_W-1:0] d, input logic [1:0] resp);
`ifdef INST_AXI_RD_ERR_EN
    return resp[1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // The model tracks the transaction by handshake events: request accepted,
  // address accepted, data accepted, done reported.
  logic              busy_m, ar_ok_m, r_ok_m, done_m, rerr_m;
  logic [ADDR_W-1:0] addr_m;
  logic [DATA_W-1:0] rdata_m;

  always @(negedge clk) begin
    if (!resetn) begin
      busy_m = 0; ar_ok_m = 0; r_ok_m = 0; done_m = 0; rerr_m = 0;
      addr_m = '0; rdata_m = '0;
    end else begin
      chk("m_busy",    axi_busy, busy_m);
      chk("m_arvalid", arvalid,  busy_m && !ar_ok_m);
      chk("m_rready",  rready,   busy_m && ar_ok_m && !r_ok_m);
      chk("m_done",    axi_done, done_m);
      chk("m_rdata",   axi_rdata, rdata_m);
      chk("m_consts",  {arid, arlen, arsize, arburst}, {ARID, 8'd0, 3'b010, 2'b01});
`ifdef INST_AXI_RD_ERR_EN
      chk("m_rerr",    axi_rerr, rerr_m);
`endif
      if (arvalid) chk("m_araddr", araddr, addr_m);
      if (axi_done) begin
        if (exp_q.size() == 0) chk("sb_unexpected_done", 1, 0);
        else chk("sb_rdata", axi_rdata, exp_q.pop_front());
      end
      if (arvalid && arready) ar_hs++;
      // advance the model to the next cycle
      if (done_m) begin
        busy_m = 0; ar_ok_m = 0; r_ok_m = 0; done_m = 0;
      end else if (busy_m) begin
        if (!ar_ok_m) begin
          if (arready) ar_ok_m = 1;
        end else if (!r_ok_m && rvalid) begin
          r_ok_m  = 1;
          done_m  = 1;
          rdata_m = exp_word(rdata, rresp);
          rerr_m  = rresp[1];
        end
      end else if (axi_start) begin
        busy_m = 1;
        addr_m = axi_addr & ~32'h3;
        rerr_m = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One read: start in cycle 0, AR held ar_wait extra cycles, R beat after
  // r_wait extra cycles. Ends in the cycle where axi_done must be high.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] exp_ar,
                         input int ar_wait, input int r_wait,
                         input logic [DATA_W-1:0] d, input logic [1:0] resp);
    tick;
    axi_start = 1; axi_addr = addr; arready = 0; rvalid = 0;
    tick;
    axi_start = 0;
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, exp_ar);
    chk("rd_arfields", {arlen, arsize, arburst}, {8'd0, 3'd2, 2'd1});
    repeat (ar_wait) tick;
    arready = 1;
    tick;
    arready = 0;
    chk("rd_rready", rready, 1);
    repeat (r_wait) tick;
    rvalid = 1; rdata = d; rresp = resp;
    exp_q.push_back(exp_word(d, resp));
    tick;
    rvalid = 0; rresp = 2'b00;
    chk("rd_done", axi_done, 1);
    chk("rd_word", axi_rdata, exp_word(d, resp));
  endtask

  task automatic wait_idle;
    int n = 0;
    while (axi_busy && n < 50) begin
      tick;
      n++;
    end
    chk("idle_timeout", axi_busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed test sequence ----------------
  initial begin
    int hs0;
    logic [ADDR_W-1:0] ra;
    resetn = 0; axi_start = 0; axi_addr = '0; arready = 0;
    rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 0;
    repeat (3) tick;
    // reset state
    chk("rst_outputs", {arvalid, rready, axi_busy, axi_done, axi_rerr}, 5'b0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_state", dbg_state, 0);
    resetn = 1;
    tick;

    // basic read at 0x4
    do_read(32'h4, 32'h4, 0, 0, 32'h24020001, 2'b00);
    tick;
    chk("basic_busy_low", axi_busy, 0);
    chk("basic_done_low", axi_done, 0);
    tick;
    chk("basic_hold", axi_rdata, 32'h24020001);

    // AR stall for 5 cycles, R beat waiting on the bus the whole time
    tick;
    axi_start = 1; axi_addr = 32'h1000; arready = 0;
    rvalid = 1; rdata = 32'hdeadbeef; rresp = 2'b00;
    tick;
    axi_start = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_arvalid", arvalid, 1);
      chk("stall_araddr", araddr, 32'h1000);
      chk("stall_busy", axi_busy, 1);
      chk("stall_rready", rready, 0);
      tick;
    end
    arready = 1;
    exp_q.push_back(32'hdeadbeef);
    tick;
    arready = 0;
    chk("stall_rready_up", rready, 1);
    tick;
    rvalid = 0;
    chk("stall_done", axi_done, 1);
    chk("stall_word", axi_rdata, 32'hdeadbeef);
    wait_idle;

    // start while in R is ignored
    hs0 = ar_hs;
    tick;
    axi_start = 1; axi_addr = 32'h100; arready = 1;
    tick;
    axi_start = 0;
    tick;
    arready = 0;
    chk("busy_in_r", rready, 1);
    axi_start = 1; axi_addr = 32'h40;
    tick;
    axi_start = 0;
    chk("busy_still_r", rready, 1);
    rvalid = 1; rdata = 32'h0badf00d; rresp = 2'b00;
    exp_q.push_back(32'h0badf00d);
    tick;
    rvalid = 0;
    chk("busy_done", axi_done, 1);
    tick;
    chk("busy_idle", axi_busy, 0);
    chk("busy_one_ar", ar_hs - hs0, 1);
    do_read(32'h40, 32'h40, 0, 0, 32'h11112222, 2'b00);
    wait_idle;
    chk("busy_second_ar", ar_hs - hs0, 2);

    // misaligned address
    do_read(32'h13, 32'h10, 0, 0, 32'h33334444, 2'b00);
    wait_idle;

    // error response
    do_read(32'h200, 32'h200, 1, 1, 32'h12345678, 2'b10);
`ifdef INST_AXI_RD_ERR_EN
    chk("err_word", axi_rdata, 32'h00000000);
    chk("err_flag", axi_rerr, 1);
`else
    chk("err_word", axi_rdata, 32'h12345678);
`endif
    wait_idle;
    do_read(32'h204, 32'h204, 0, 0, 32'h55556666, 2'b00);
    chk("err_cleared", axi_rerr, 0);
    wait_idle;

    // varied stalls, data and responses
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      do_read(ra, ra & ~32'h3, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, 2'($urandom_range(0, 3)));
      wait_idle;
    end

    // asynchronous reset in the middle of a read
    tick;
    axi_start = 1; axi_addr = 32'h80; arready = 0;
    tick;
    axi_start = 0;
    chk("arst_pre", arvalid, 1);
    #2;
    resetn = 0;
    #1;
    chk("arst_outputs", {arvalid, rready, axi_busy, axi_done}, 4'b0);
    chk("arst_rdata", axi_rdata, 0);
    chk("arst_araddr", araddr, 0);
    tick;
    tick;
    resetn = 1;
    tick;
    chk("arst_idle", axi_busy, 0);
    do_read(32'h84, 32'h84, 0, 0, 32'h77778888, 2'b00);
    wait_idle;

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
